// File: rtl/tm_pkg.sv
// ---------------------------------------------------------------------------
// tm_pkg : shared definitions for the Turing machine datapath.
//   dir_t          head direction carried by each transition
//   tape_state_t   control state of the tape unit
//   BLANK_SYM      value of the blank symbol (all cells reset to it)
// ---------------------------------------------------------------------------
package tm_pkg;

    typedef enum logic [1:0] {
        DIR_STAY  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_HALT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } tape_state_t;

    localparam int unsigned BLANK_SYM = 0;

endpackage

// File: rtl/tm_tape_mem.sv
// ---------------------------------------------------------------------------
// tm_tape_mem : TAPE_LEN x SYM_W register array, one write port and one
// combinational read port with write-first forwarding. Synchronous clear.
//   clock   in   rising-edge clock
//   Reset   in   synchronous active-high clear of every cell to blank
//   we      in   write enable
//   waddr   in   write address
//   wdata   in   write data
//   raddr   in   read address
//   rdata   out  cell at raddr, or wdata when writing the same cell
// ---------------------------------------------------------------------------
module tm_tape_mem
    import tm_pkg::*;
#(
    parameter int SYM_W    = 2,
    parameter int TAPE_LEN = 64,
    parameter int ADDR_W   = $clog2(TAPE_LEN)
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SYM_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [SYM_W-1:0]  rdata
);

    logic [SYM_W-1:0] mem_q [TAPE_LEN];

    // Cell storage: clear on reset, otherwise single-port write.
    always_ff @(posedge clock) begin
        if (Reset) begin
            for (int i = 0; i < TAPE_LEN; i++) begin
                mem_q[i] <= SYM_W'(BLANK_SYM);
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port: forward the in-flight write so the caller sees write-first data.
    always_comb begin
        rdata = mem_q[raddr];
        if (we && (waddr == raddr)) begin
            rdata = wdata;
        end else begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/tm_tape.sv
// ---------------------------------------------------------------------------
// tm_tape : tape unit downstream of the TuringMachine. Loads the initial
// tape from the host, then applies each transition (write symbol at the
// head, move the head) and returns the registered symbol under the head.
//
// Configuration macro: TM_TAPE_WRAP_EN
//   defined     head wraps modulo TAPE_LEN, FAULT unreachable, fault = 0
//   undefined   boundary move is suppressed (write still happens) and the
//               unit enters FAULT
//
// Ports:
//   clock       in   rising-edge clock
//   Reset       in   synchronous active-high reset
//   load_valid  in   write load_sym at the load pointer (LOAD only)
//   load_sym    in   initial tape symbol
//   start       in   end of load, enter RUN with head at 0
//   step_valid  in   transition available
//   step_ready  out  high in RUN (state decode)
//   write_sym   in   symbol written at the head
//   direction   in   0 stay, 1 left, 2 right, 3 halt
//   read_sym    out  registered symbol under the head
//   head_pos    out  current head index
//   halted      out  high in HALT
//   fault       out  high in FAULT
// ---------------------------------------------------------------------------
module tm_tape
    import tm_pkg::*;
#(
    parameter int SYM_W    = 2,
    parameter int TAPE_LEN = 64,
    parameter int ADDR_W   = $clog2(TAPE_LEN)
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              load_valid,
    input  logic [SYM_W-1:0]  load_sym,
    input  logic              start,
    input  logic              step_valid,
    output logic              step_ready,
    input  logic [SYM_W-1:0]  write_sym,
    input  logic [1:0]        direction,
    output logic [SYM_W-1:0]  read_sym,
    output logic [ADDR_W-1:0] head_pos,
    output logic              halted,
    output logic              fault
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(TAPE_LEN - 1);
    localparam logic [ADDR_W:0]   PTR_FULL  = (ADDR_W + 1)'(TAPE_LEN);

    tape_state_t       state_q, state_d;
    // One extra bit so the pointer can saturate at TAPE_LEN (tape full).
    logic [ADDR_W:0]   load_ptr_q, load_ptr_d;
    logic [ADDR_W-1:0] head_q, head_d;
    logic [SYM_W-1:0]  read_q, read_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [SYM_W-1:0]  mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [SYM_W-1:0]  mem_rdata;

    tm_tape_mem #(
        .SYM_W   (SYM_W),
        .TAPE_LEN(TAPE_LEN),
        .ADDR_W  (ADDR_W)
    ) u_mem (
        .clock(clock),
        .Reset(Reset),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .raddr(mem_raddr),
        .rdata(mem_rdata)
    );

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q    <= LOAD;
            load_ptr_q <= '0;
            head_q     <= '0;
            read_q     <= SYM_W'(BLANK_SYM);
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            head_q     <= head_d;
            read_q     <= read_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    // Next-state: load writes, start, and step execution with boundary handling.
    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        head_d     = head_q;
        read_d     = read_q;
        mem_we     = 1'b0;
        mem_waddr  = head_q;
        mem_wdata  = write_sym;
        mem_raddr  = head_q;

        case (state_q)
            LOAD: begin
                if (load_valid && (load_ptr_q < PTR_FULL)) begin
                    mem_we     = 1'b1;
                    mem_waddr  = load_ptr_q[ADDR_W-1:0];
                    mem_wdata  = load_sym;
                    load_ptr_d = load_ptr_q + (ADDR_W + 1)'(1);
                end else begin
                    load_ptr_d = load_ptr_q;
                end
                if (start) begin
                    state_d   = RUN;
                    head_d    = '0;
                    mem_raddr = '0;
                    read_d    = mem_rdata;
                end else begin
                    state_d = LOAD;
                end
            end
            RUN: begin
                if (step_valid) begin
                    if (dir_t'(direction) == DIR_HALT) begin
                        state_d = HALT;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = head_q;
                        mem_wdata = write_sym;
                        case (dir_t'(direction))
                            DIR_LEFT: begin
                                if (head_q == '0) begin
`ifdef TM_TAPE_WRAP_EN
                                    head_d = LAST_CELL;
`else
                                    head_d  = head_q;
                                    state_d = FAULT;
`endif
                                end else begin
                                    head_d = head_q - ADDR_W'(1);
                                end
                            end
                            DIR_RIGHT: begin
                                if (head_q == LAST_CELL) begin
`ifdef TM_TAPE_WRAP_EN
                                    head_d = '0;
`else
                                    head_d  = head_q;
                                    state_d = FAULT;
`endif
                                end else begin
                                    head_d = head_q + ADDR_W'(1);
                                end
                            end
                            default: begin
                                head_d = head_q;
                            end
                        endcase
                        // Forwarding covers the stay / suppressed-move case.
                        mem_raddr = head_d;
                        read_d    = mem_rdata;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Status flags registered from the next state so they align with head/read.
    always_comb begin
        halted_d = (state_d == HALT);
`ifdef TM_TAPE_WRAP_EN
        fault_d = 1'b0;
`else
        fault_d = (state_d == FAULT);
`endif
    end

    assign step_ready = (state_q == RUN);
    assign read_sym   = read_q;
    assign head_pos   = head_q;
    assign halted     = halted_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_tm_tape.sv
// ---------------------------------------------------------------------------
// tb_tm_tape : directed self-checking bench for tm_tape (64 cells, 2-bit
// symbols). Expectations follow TM_TAPE_WRAP_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_tm_tape;

    logic       clock = 1'b0;
    logic       Reset = 1'b1;
    logic       load_valid = 1'b0;
    logic [1:0] load_sym = 2'd0;
    logic       start = 1'b0;
    logic       step_valid = 1'b0;
    logic       step_ready;
    logic [1:0] write_sym = 2'd0;
    logic [1:0] direction = 2'd0;
    logic [1:0] read_sym;
    logic [5:0] head_pos;
    logic       halted;
    logic       fault;

    int checks_cnt = 0;
    int errors_cnt = 0;

    tm_tape dut (
        .clock     (clock),
        .Reset     (Reset),
        .load_valid(load_valid),
        .load_sym  (load_sym),
        .start     (start),
        .step_valid(step_valid),
        .step_ready(step_ready),
        .write_sym (write_sym),
        .direction (direction),
        .read_sym  (read_sym),
        .head_pos  (head_pos),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_step(input logic [1:0] ws, input logic [1:0] dir);
        step_valid = 1'b1;
        write_sym  = ws;
        direction  = dir;
        tick();
        step_valid = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] s);
        load_valid = 1'b1;
        load_sym   = s;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        // Reset for two cycles.
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        check_val("rst_head", head_pos, 0);
        check_val("rst_read", read_sym, 0);
        check_val("rst_ready", step_ready, 0);
        check_val("rst_halted", halted, 0);
        check_val("rst_fault", fault, 0);

        // Load 3,1,1,2 then start.
        do_load(2'd3);
        do_load(2'd1);
        do_load(2'd1);
        do_load(2'd2);
        check_val("load_ready", step_ready, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_read", read_sym, 3);
        check_val("start_head", head_pos, 0);
        check_val("start_ready", step_ready, 1);

        // Right moves.
        do_step(2'd2, 2'd2);
        check_val("r1_head", head_pos, 1);
        check_val("r1_read", read_sym, 1);
        do_step(2'd0, 2'd2);
        check_val("r2_head", head_pos, 2);
        check_val("r2_read", read_sym, 1);

        // Stay with forwarding at head 2.
        do_step(2'd3, 2'd0);
        check_val("stay_head", head_pos, 2);
        check_val("stay_read", read_sym, 3);

        // Walk back left to confirm cell1=0 and cell0=2.
        do_step(2'd3, 2'd1);
        check_val("l1_head", head_pos, 1);
        check_val("cell1", read_sym, 0);
        do_step(2'd0, 2'd1);
        check_val("l2_head", head_pos, 0);
        check_val("cell0", read_sym, 2);

        // Left boundary from head 0, writing 1.
        do_step(2'd1, 2'd1);
`ifdef TM_TAPE_WRAP_EN
        check_val("bnd_head", head_pos, 63);
        check_val("bnd_fault", fault, 0);
        check_val("bnd_ready", step_ready, 1);
        check_val("bnd_read", read_sym, 0);
        // Right from 63 wraps to 0, which now holds 1.
        do_step(2'd0, 2'd2);
        check_val("wrap_head", head_pos, 0);
        check_val("wrap_read", read_sym, 1);
`else
        check_val("bnd_head", head_pos, 0);
        check_val("bnd_fault", fault, 1);
        check_val("bnd_ready", step_ready, 0);
        check_val("bnd_read", read_sym, 1);
        // FAULT ignores further steps.
        do_step(2'd2, 2'd2);
        check_val("flt_head", head_pos, 0);
        check_val("flt_fault", fault, 1);
`endif

        // Reset mid-run, then load+start in the same cycle (write-first).
        step_valid = 1'b1;
        write_sym  = 2'd3;
        direction  = 2'd2;
        Reset      = 1'b1;
        tick();
        Reset      = 1'b0;
        step_valid = 1'b0;
        check_val("rst2_head", head_pos, 0);
        check_val("rst2_read", read_sym, 0);
        check_val("rst2_ready", step_ready, 0);
        check_val("rst2_fault", fault, 0);
        load_valid = 1'b1;
        load_sym   = 2'd2;
        start      = 1'b1;
        tick();
        load_valid = 1'b0;
        start      = 1'b0;
        check_val("ls_read", read_sym, 2);
        check_val("ls_ready", step_ready, 1);

        // Cells 1 and 2 were cleared by reset.
        do_step(2'd1, 2'd2);
        check_val("clr1", read_sym, 0);
        do_step(2'd1, 2'd2);
        check_val("clr2", read_sym, 0);
        check_val("clr_head", head_pos, 2);

        // Halt: no write, no move.
        do_step(2'd3, 2'd3);
        check_val("halt_flag", halted, 1);
        check_val("halt_ready", step_ready, 0);
        check_val("halt_head", head_pos, 2);
        check_val("halt_read", read_sym, 0);
        do_step(2'd2, 2'd1);
        check_val("halt_ign_head", head_pos, 2);
        check_val("halt_ign_read", read_sym, 0);
        check_val("halt_hold", halted, 1);

        // Reset clears the tape and returns to LOAD.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_val("rst3_halted", halted, 0);
        check_val("rst3_ready", step_ready, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("rst3_cell0", read_sym, 0);
        do_step(2'd0, 2'd2);
        check_val("rst3_cell1", read_sym, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
